// File: rtl/palette_memory.sv
// Colour table fed by the palette command decoder, with a 32-cycle clear walk on reset or clear command.
// Lookup latency 2 cycles, one request per cycle, no backpressure; decoder writes are dropped while clearing.
module palette_memory #(
   parameter int IDX_W = 5,
   parameter int CH_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rstPalette,
   input  logic               wPalette,
   input  logic [IDX_W-1:0]   controllerColor,
   input  logic               controllerRGB,
   input  logic [2*CH_W-1:0]  wData,
   input  logic               pixValid,
   input  logic [IDX_W-1:0]   pixIndex,
   output logic               rgbValid,
   output logic [3*CH_W-1:0]  rgbOut,
   output logic               clearBusy
);

   localparam int               NUM_COLORS = 2**IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COLORS - 1);
   localparam logic [0:0]       S_IDLE     = 1'b0;
   localparam logic [0:0]       S_CLEAR    = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
   logic              clearing;

   // RG and B kept in separate arrays so each half-word write touches only its own channels
   logic [2*CH_W-1:0] rg_mem [NUM_COLORS];
   logic [CH_W-1:0]   b_mem  [NUM_COLORS];

   logic              host_wr;
   logic              rg_we, b_we;
   logic [IDX_W-1:0]  wr_addr;
   logic [2*CH_W-1:0] rg_wdat;
   logic [CH_W-1:0]   b_wdat;

   logic              s1_vld_q;
   logic [IDX_W-1:0]  s1_idx_q;
   logic              rgb_vld_q;
   logic [3*CH_W-1:0] rgb_q, rgb_d;

   assign clearing = (state_q == S_CLEAR);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         S_CLEAR: begin
            if (!rstPalette) begin
               clr_idx_d = '0;
            end else if (clr_idx_q == LAST_IDX) begin
               state_d = S_IDLE;
            end else begin
               clr_idx_d = clr_idx_q + IDX_W'(1);
            end
         end
         default: begin
            if (!rstPalette) begin
               state_d   = S_CLEAR;
               clr_idx_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // A clear request in the same cycle as a write wins: the write is simply not issued
   assign host_wr = !clearing && rstPalette && wPalette;
   assign wr_addr = clearing ? clr_idx_q : controllerColor;
   assign rg_we   = clearing || (host_wr && !controllerRGB);
   assign b_we    = clearing || (host_wr && controllerRGB);
   assign rg_wdat = clearing ? '0 : wData;
   assign b_wdat  = clearing ? '0 : wData[2*CH_W-1:CH_W];

   always_ff @(posedge clk) begin
      if (rg_we) begin
         rg_mem[wr_addr] <= rg_wdat;
      end
      if (b_we) begin
         b_mem[wr_addr] <= b_wdat;
      end
   end

   // Stage-2 read sees the table before any write committed on the same edge
   assign rgb_d = clearing ? '0 : {rg_mem[s1_idx_q], b_mem[s1_idx_q]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_idx_q  <= '0;
         rgb_vld_q <= 1'b0;
         rgb_q     <= '0;
      end else begin
         s1_vld_q  <= pixValid;
         s1_idx_q  <= pixIndex;
         rgb_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            rgb_q <= rgb_d;
         end
      end
   end

   assign rgbValid  = rgb_vld_q;
   assign rgbOut    = rgb_q;
   assign clearBusy = clearing;

endmodule

// File: tb/tb_palette_memory.sv
// Directed bench for palette_memory: clear walk, writes, pipelined lookups, clear priority, collisions, async reset.
module tb_palette_memory;

   logic        clk;
   logic        rst_n;
   logic        rstPalette;
   logic        wPalette;
   logic [4:0]  controllerColor;
   logic        controllerRGB;
   logic [15:0] wData;
   logic        pixValid;
   logic [4:0]  pixIndex;
   logic        rgbValid;
   logic [23:0] rgbOut;
   logic        clearBusy;

   int vectors;
   int miscompares;

   palette_memory #(.IDX_W(5), .CH_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rstPalette      (rstPalette),
      .wPalette        (wPalette),
      .controllerColor (controllerColor),
      .controllerRGB   (controllerRGB),
      .wData           (wData),
      .pixValid        (pixValid),
      .pixIndex        (pixIndex),
      .rgbValid        (rgbValid),
      .rgbOut          (rgbOut),
      .clearBusy       (clearBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [4:0] idx, output logic [23:0] dat, output logic vld);
      pixValid = 1'b1;
      pixIndex = idx;
      tick();
      pixValid = 1'b0;
      tick();
      dat = rgbOut;
      vld = rgbValid;
   endtask

   task automatic wr(input logic [4:0] idx, input logic sel, input logic [15:0] dat);
      wPalette        = 1'b1;
      controllerColor = idx;
      controllerRGB   = sel;
      wData           = dat;
      tick();
      wPalette = 1'b0;
   endtask

   task automatic count_busy(input int start, output int n);
      n = start;
      while (clearBusy && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [23:0] d;
      logic        v;
      int          n;
      rst_n = 1'b0;
      tick(); tick(); tick();
      vectors++;
      if (clearBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_busy: got %b want 1", clearBusy);
      end
      vectors++;
      if (rgbValid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b want 0", rgbValid);
      end
      vectors++;
      if (rgbOut !== 24'h000000) begin
         miscompares++;
         $display("FAIL reset_rgb: got %h want 000000", rgbOut);
      end
      rst_n = 1'b1;
      count_busy(0, n);
      vectors++;
      if (n !== 32) begin
         miscompares++;
         $display("FAIL reset_clear_len: got %0d cycles want 32", n);
      end
      for (int i = 0; i < 32; i++) begin
         lookup(5'(i), d, v);
         vectors++;
         if (v !== 1'b1 || d !== 24'h000000) begin
            miscompares++;
            $display("FAIL reset_slot%0d: got v=%b %h want v=1 000000", i, v, d);
         end
      end
   endtask

   task automatic test_write_read();
      logic [23:0] d;
      logic        v;
      wr(5'd5, 1'b0, 16'hA1B2);
      wr(5'd5, 1'b1, 16'hC3FF);
      pixValid = 1'b1;
      pixIndex = 5'd5;
      tick();
      pixValid = 1'b0;
      vectors++;
      if (rgbValid !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_latency1: got valid %b want 0", rgbValid);
      end
      tick();
      vectors++;
      if (rgbValid !== 1'b1 || rgbOut !== 24'hA1B2C3) begin
         miscompares++;
         $display("FAIL wr_slot5: got v=%b %h want v=1 a1b2c3", rgbValid, rgbOut);
      end
      lookup(5'd6, d, v);
      vectors++;
      if (v !== 1'b1 || d !== 24'h000000) begin
         miscompares++;
         $display("FAIL wr_slot6: got v=%b %h want v=1 000000", v, d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  b;
      logic [23:0] exp;
      for (int i = 0; i < 32; i++) begin
         b = 8'(i);
         wr(5'(i), 1'b0, {b, b});
         wr(5'(i), 1'b1, {b, 8'h00});
      end
      for (int c = 0; c <= 32; c++) begin
         pixValid = (c < 32);
         pixIndex = 5'(c);
         tick();
         vectors++;
         if (c == 0) begin
            if (rgbValid !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_first_gap: got valid %b want 0", rgbValid);
            end
         end else begin
            b   = 8'(c - 1);
            exp = {b, b, b};
            if (rgbValid !== 1'b1 || rgbOut !== exp) begin
               miscompares++;
               $display("FAIL b2b_res%0d: got v=%b %h want v=1 %h", c - 1, rgbValid, rgbOut, exp);
            end
         end
      end
      pixValid = 1'b0;
      tick();
      vectors++;
      if (rgbValid !== 1'b0 || rgbOut !== 24'h1F1F1F) begin
         miscompares++;
         $display("FAIL b2b_hold: got v=%b %h want v=0 1f1f1f", rgbValid, rgbOut);
      end
   endtask

   task automatic test_clear_priority();
      logic [23:0] d;
      logic        v;
      int          n;
      rstPalette      = 1'b0;
      wPalette        = 1'b1;
      controllerColor = 5'd3;
      controllerRGB   = 1'b0;
      wData           = 16'hFFFF;
      tick();
      rstPalette = 1'b1;
      wPalette   = 1'b0;
      vectors++;
      if (clearBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL clr_enter: got busy %b want 1", clearBusy);
      end
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin
            wPalette        = 1'b1;
            controllerColor = 5'd0;
            controllerRGB   = 1'b0;
            wData           = 16'h5555;
         end
         tick();
         wPalette = 1'b0;
      end
      rstPalette = 1'b0;
      tick();
      rstPalette = 1'b1;
      lookup(5'd20, d, v);
      vectors++;
      if (v !== 1'b1 || d !== 24'h000000) begin
         miscompares++;
         $display("FAIL clr_read_busy: got v=%b %h want v=1 000000", v, d);
      end
      count_busy(2, n);
      vectors++;
      if (n !== 32) begin
         miscompares++;
         $display("FAIL clr_restart_len: got %0d cycles want 32", n);
      end
      lookup(5'd3, d, v);
      vectors++;
      if (d !== 24'h000000) begin
         miscompares++;
         $display("FAIL clr_slot3: got %h want 000000", d);
      end
      lookup(5'd0, d, v);
      vectors++;
      if (d !== 24'h000000) begin
         miscompares++;
         $display("FAIL clr_slot0_drop: got %h want 000000", d);
      end
      lookup(5'd20, d, v);
      vectors++;
      if (d !== 24'h000000) begin
         miscompares++;
         $display("FAIL clr_slot20: got %h want 000000", d);
      end
   endtask

   task automatic test_collision();
      wr(5'd9, 1'b0, 16'hABCD);
      wr(5'd9, 1'b1, 16'hEE00);
      pixValid = 1'b1;
      pixIndex = 5'd9;
      tick();
      wPalette        = 1'b1;
      controllerColor = 5'd9;
      controllerRGB   = 1'b0;
      wData           = 16'h1234;
      tick();
      wPalette = 1'b0;
      pixValid = 1'b0;
      vectors++;
      if (rgbValid !== 1'b1 || rgbOut !== 24'hABCDEE) begin
         miscompares++;
         $display("FAIL coll_old: got v=%b %h want v=1 abcdee", rgbValid, rgbOut);
      end
      tick();
      vectors++;
      if (rgbValid !== 1'b1 || rgbOut !== 24'h1234EE) begin
         miscompares++;
         $display("FAIL coll_new: got v=%b %h want v=1 1234ee", rgbValid, rgbOut);
      end
   endtask

   task automatic test_async_reset();
      logic [23:0] d;
      logic        v;
      int          n;
      int          bad;
      pixValid        = 1'b1;
      pixIndex        = 5'd9;
      wPalette        = 1'b1;
      controllerColor = 5'd7;
      controllerRGB   = 1'b0;
      wData           = 16'h7777;
      tick();
      tick();
      vectors++;
      if (rgbValid !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_pre: got valid %b want 1", rgbValid);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (rgbValid !== 1'b0 || clearBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_async: got v=%b busy=%b want v=0 busy=1", rgbValid, clearBusy);
      end
      pixValid = 1'b0;
      wPalette = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      count_busy(0, n);
      vectors++;
      if (n !== 32) begin
         miscompares++;
         $display("FAIL areset_clear_len: got %0d cycles want 32", n);
      end
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         lookup(5'(i), d, v);
         if (v !== 1'b1 || d !== 24'h000000) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL areset_slots: got %0d nonzero slots want 0", bad);
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst_n           = 1'b0;
      rstPalette      = 1'b1;
      wPalette        = 1'b0;
      controllerColor = '0;
      controllerRGB   = 1'b0;
      wData           = '0;
      pixValid        = 1'b0;
      pixIndex        = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_clear_priority();
      test_collision();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
